// File: rtl/usb_frame_loader.sv
// usb_frame_loader: packs the USB receive byte stream into complex 16+16-bit
// samples, buffers one frame of N_POINTS samples in an internal RAM and, once
// the FFT core is ready, streams the frame out one sample per cycle.
// Optional feature macro: USB_FRAME_LOADER_HEADER_SYNC_EN. When it is defined,
// every frame must be preceded by the sync bytes 0xA5, 0x5A.
module usb_frame_loader #(
  parameter int N_POINTS = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  usb_data,
  input  logic        usb_valid,
  output logic        usb_ready,
  input  logic        fft_ready,
  output logic [15:0] data_out_re,
  output logic [15:0] data_out_im,
  output logic        data_out_valid,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_full
);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_WAIT,
    ST_STREAM
`ifdef USB_FRAME_LOADER_HEADER_SYNC_EN
    , ST_SYNC0,
    ST_SYNC1
`endif
  } state_t;

  // State entered after reset and after each streamed frame.
`ifdef USB_FRAME_LOADER_HEADER_SYNC_EN
  localparam state_t ST_IDLE = ST_SYNC0;
`else
  localparam state_t ST_IDLE = ST_FILL;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 1);

  state_t            r_state;
  state_t            w_state_next;

  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_byte_buf;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_active;

  logic [31:0]       r_mem [N_POINTS];
  logic [31:0]       r_ram_q;
  logic              r_q_valid;
  logic              r_q_first;
  logic              r_q_last;

  logic              r_usb_ready;
  logic              r_frame_full;
  logic              r_data_valid;
  logic              r_frame_start;
  logic              r_frame_done;
  logic [15:0]       r_data_re;
  logic [15:0]       r_data_im;

  logic              w_accept;
  logic              w_wr_en;
  logic              w_last_write;
  logic              w_accepting_next;

  assign w_accept     = usb_valid && r_usb_ready;
  assign w_wr_en      = w_accept && (r_state == ST_FILL) && (r_byte_cnt == 2'd3);
  assign w_last_write = w_wr_en && (r_wr_addr == LAST_ADDR);

`ifdef USB_FRAME_LOADER_HEADER_SYNC_EN
  assign w_accepting_next = (w_state_next == ST_FILL) || (w_state_next == ST_SYNC0) ||
                            (w_state_next == ST_SYNC1);
`else
  assign w_accepting_next = (w_state_next == ST_FILL);
`endif

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: sync hunt, fill, wait for the FFT, stream.
  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch forms.
    w_state_next = r_state;
    case (r_state)
`ifdef USB_FRAME_LOADER_HEADER_SYNC_EN
      ST_SYNC0: if (w_accept && (usb_data == 8'hA5)) w_state_next = ST_SYNC1;
      ST_SYNC1: begin
        if (w_accept) begin
          if (usb_data == 8'h5A)      w_state_next = ST_FILL;
          else if (usb_data == 8'hA5) w_state_next = ST_SYNC1;
          else                        w_state_next = ST_SYNC0;
        end
      end
`endif
      ST_FILL:   if (w_last_write) w_state_next = ST_WAIT;
      ST_WAIT:   if (fft_ready)    w_state_next = ST_STREAM;
      ST_STREAM: if (r_frame_done) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Byte assembly and write address; both rewind while the frame streams out.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_byte_cnt <= '0;
      r_byte_buf <= '0;
      r_wr_addr  <= '0;
    end else if (r_state == ST_STREAM) begin
      r_byte_cnt <= '0;
      r_wr_addr  <= '0;
    end else if (w_accept && (r_state == ST_FILL)) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_byte_buf <= {r_byte_buf[15:0], usb_data};
      if (w_wr_en) r_wr_addr <= r_wr_addr + ADDR_W'(1);
    end
  end

  // Frame RAM: one write port for assembled samples, one registered read port.
  always_ff @(posedge CLK) begin
    // NOTE: the RAM has no reset so it maps onto block RAM; stale contents are
    // harmless because a frame streams only after all entries were rewritten.
    if (w_wr_en) r_mem[r_wr_addr] <= {r_byte_buf, usb_data};
    r_ram_q <= r_mem[r_rd_addr];
  end

  // Read sequencer: issues addresses 0..N_POINTS-1 back to back after WAIT.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_rd_addr   <= '0;
      r_rd_active <= 1'b0;
      r_q_valid   <= 1'b0;
      r_q_first   <= 1'b0;
      r_q_last    <= 1'b0;
    end else begin
      r_q_valid <= r_rd_active;
      r_q_first <= (r_rd_addr == '0);
      r_q_last  <= (r_rd_addr == LAST_ADDR);
      if ((r_state == ST_WAIT) && fft_ready) begin
        r_rd_addr   <= '0;
        r_rd_active <= 1'b1;
      end else if (r_rd_active) begin
        r_rd_addr <= r_rd_addr + ADDR_W'(1);
        if (r_rd_addr == LAST_ADDR) r_rd_active <= 1'b0;
      end
    end
  end

  // Registered outputs; sample data holds its value between frames.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_usb_ready   <= 1'b0;
      r_frame_full  <= 1'b0;
      r_data_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_data_re     <= '0;
      r_data_im     <= '0;
    end else begin
      r_usb_ready   <= w_accepting_next;
      r_frame_full  <= (w_state_next == ST_WAIT);
      r_data_valid  <= r_q_valid;
      r_frame_start <= r_q_valid && r_q_first;
      r_frame_done  <= r_q_valid && r_q_last;
      if (r_q_valid) begin
        r_data_re <= r_ram_q[31:16];
        r_data_im <= r_ram_q[15:0];
      end
    end
  end

  assign usb_ready      = r_usb_ready;
  assign frame_full     = r_frame_full;
  assign data_out_valid = r_data_valid;
  assign frame_start    = r_frame_start;
  assign frame_done     = r_frame_done;
  assign data_out_re    = r_data_re;
  assign data_out_im    = r_data_im;

endmodule

// File: tb/tb_usb_frame_loader.sv
// Testbench for usb_frame_loader with an 8-point frame. Expected samples are
// derived from the sent byte list (big-endian re then im, 4 bytes per sample).
module tb_usb_frame_loader;

  localparam int N  = 8;
  localparam int AW = 3;

  typedef logic [7:0] bq_t[$];

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  usb_data = 8'h00;
  logic        usb_valid = 1'b0;
  logic        usb_ready;
  logic        fft_ready = 1'b0;
  logic [15:0] data_out_re;
  logic [15:0] data_out_im;
  logic        data_out_valid;
  logic        frame_start;
  logic        frame_done;
  logic        frame_full;

  int checks = 0;
  int errors = 0;

  usb_frame_loader #(.N_POINTS(N), .ADDR_W(AW)) dut (
    .CLK(CLK),
    .reset(reset),
    .usb_data(usb_data),
    .usb_valid(usb_valid),
    .usb_ready(usb_ready),
    .fft_ready(fft_ready),
    .data_out_re(data_out_re),
    .data_out_im(data_out_im),
    .data_out_valid(data_out_valid),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .frame_full(frame_full)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Data bytes of one frame: counting pattern or random.
  task automatic make_frame(input bit counting, output bq_t d);
    d = {};
    for (int k = 0; k < N; k++) begin
      if (counting) begin
        d.push_back(8'h01); d.push_back(8'(k)); d.push_back(8'h02); d.push_back(8'(k));
      end else begin
        for (int j = 0; j < 4; j++) d.push_back(8'($urandom));
      end
    end
  endtask

  // Wire-level byte sequence for a frame (with the sync header when enabled).
  task automatic with_sync(input bq_t d, output bq_t s);
    s = d;
`ifdef USB_FRAME_LOADER_HEADER_SYNC_EN
    s.push_front(8'h5A);
    s.push_front(8'hA5);
`endif
  endtask

  // Called at a negedge; drives bytes, counting one as taken when valid and
  // ready are both high at the following edge. Returns at the negedge after
  // the last accepting edge.
  task automatic send_bytes(input bq_t b, input bit gaps, input string tag);
    int idx = 0;
    int cyc = 0;
    while (idx < b.size() && cyc < 4000) begin
      logic v;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      usb_valid = v;
      usb_data  = v ? b[idx] : 8'($urandom);
      if (v && usb_ready) idx++;
      cyc++;
      @(negedge CLK);
    end
    check({tag, "_bytes_sent"}, 32'(idx), 32'(b.size()));
  endtask

  // Called at the negedge just before the edge that samples fft_ready==1.
  task automatic check_stream(input bq_t d, input bit keep_valid, input string tag);
    logic [31:0] exp;
    exp = '0;
    usb_valid = keep_valid;
    @(negedge CLK);
    if (keep_valid) usb_data = 8'($urandom);
    check({tag, "_lat1_valid"}, 32'(data_out_valid), 32'd0);
    check({tag, "_full_drop"}, 32'(frame_full), 32'd0);
    @(negedge CLK);
    if (keep_valid) usb_data = 8'($urandom);
    check({tag, "_lat2_valid"}, 32'(data_out_valid), 32'd0);
    for (int k = 0; k < N; k++) begin
      @(negedge CLK);
      if (keep_valid) usb_data = 8'($urandom);
      exp = {d[4*k], d[4*k+1], d[4*k+2], d[4*k+3]};
      check({tag, "_valid"}, 32'(data_out_valid), 32'd1);
      check({tag, "_sample"}, {data_out_re, data_out_im}, exp);
      check({tag, "_start"}, 32'(frame_start), 32'(k == 0));
      check({tag, "_done"}, 32'(frame_done), 32'(k == N - 1));
      check({tag, "_ready_low"}, 32'(usb_ready), 32'd0);
    end
    @(negedge CLK);
    usb_valid = 1'b0;
    check({tag, "_end_valid"}, 32'(data_out_valid), 32'd0);
    check({tag, "_end_done"}, 32'(frame_done), 32'd0);
    check({tag, "_hold"}, {data_out_re, data_out_im}, exp);
    check({tag, "_ready_back"}, 32'(usb_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(usb_ready), 32'd0);
    check({tag, "_valid"}, 32'(data_out_valid), 32'd0);
    check({tag, "_start"}, 32'(frame_start), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_full"}, 32'(frame_full), 32'd0);
    check({tag, "_data"}, {data_out_re, data_out_im}, 32'd0);
  endtask

  initial begin
    bq_t d;
    bq_t s;

    // Reset state.
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst0");
    reset = 1'b1;
    @(negedge CLK);
    check("rst0_ready_after", 32'(usb_ready), 32'd1);

    // Counting frame, no gaps, fft_ready already high: WAIT lasts one cycle.
    fft_ready = 1'b1;
    make_frame(1'b1, d);
    with_sync(d, s);
    send_bytes(s, 1'b0, "t1");
    usb_valid = 1'b0;
    check("t1_ready_after_fill", 32'(usb_ready), 32'd0);
    check("t1_full_after_fill", 32'(frame_full), 32'd1);
    check_stream(d, 1'b0, "t1");

    // Same frame with random gaps; FFT held off 20 cycles; usb_valid kept high while streaming.
    fft_ready = 1'b0;
    make_frame(1'b1, d);
    with_sync(d, s);
    send_bytes(s, 1'b1, "t2");
    usb_valid = 1'b0;
    check("t2_full_after_fill", 32'(frame_full), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("t2_wait_full", 32'(frame_full), 32'd1);
      check("t2_wait_ready", 32'(usb_ready), 32'd0);
      check("t2_wait_valid", 32'(data_out_valid), 32'd0);
    end
    fft_ready = 1'b1;
    check_stream(d, 1'b1, "t2");

    // Random frame right after a stream with junk presented: nothing junk was stored.
    fft_ready = 1'b0;
    make_frame(1'b0, d);
    with_sync(d, s);
    send_bytes(s, 1'b1, "t3");
    usb_valid = 1'b0;
    check("t3_full_after_fill", 32'(frame_full), 32'd1);
    @(negedge CLK);
    fft_ready = 1'b1;
    check_stream(d, 1'b0, "t3");

    // Reset after 13 bytes, then a fresh frame.
    fft_ready = 1'b0;
    make_frame(1'b0, d);
    with_sync(d, s);
    while (s.size() > 13) void'(s.pop_back());
    send_bytes(s, 1'b0, "t4_part");
    usb_valid = 1'b0;
    reset = 1'b0;
    @(negedge CLK);
    check_reset_outputs("t4_rst");
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("t4_ready_after", 32'(usb_ready), 32'd1);
    make_frame(1'b0, d);
    with_sync(d, s);
    send_bytes(s, 1'b1, "t4");
    usb_valid = 1'b0;
    check("t4_full_after_fill", 32'(frame_full), 32'd1);
    fft_ready = 1'b1;
    check_stream(d, 1'b0, "t4");

    // Two back-to-back frames with fft_ready held high.
    for (int f = 0; f < 2; f++) begin
      make_frame(1'b0, d);
      with_sync(d, s);
      send_bytes(s, 1'b0, "t5");
      usb_valid = 1'b0;
      check("t5_full_after_fill", 32'(frame_full), 32'd1);
      check_stream(d, 1'b0, "t5");
    end

`ifdef USB_FRAME_LOADER_HEADER_SYNC_EN
    // Sync hunt with false starts before the data bytes.
    make_frame(1'b0, d);
    s = {};
    s.push_back(8'h00); s.push_back(8'hA5); s.push_back(8'h11);
    s.push_back(8'hA5); s.push_back(8'hA5); s.push_back(8'h5A);
    foreach (d[i]) s.push_back(d[i]);
    send_bytes(s, 1'b0, "t6");
    usb_valid = 1'b0;
    check("t6_full_after_fill", 32'(frame_full), 32'd1);
    check_stream(d, 1'b0, "t6");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
